// File: rtl/power_switch_emulator.sv
// Emulates per-domain power switches: request -> ack after a fixed LATENCY, with abort, busy and isolation checking.
// Latency: ack flips exactly LATENCY edges after the request is first sampled; status outputs are registered (1 cycle).
module power_switch_emulator #(
    parameter int NUM_DOMAINS = 4,
    parameter int LATENCY     = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] switch_n_i,
    input  logic [NUM_DOMAINS-1:0] iso_n_i,
    input  logic                   clr_i,
    output logic [NUM_DOMAINS-1:0] switch_ack_no,
    output logic                   busy_o,
    output logic                   abort_o,
    output logic [7:0]             abort_cnt_o,
    output logic [NUM_DOMAINS-1:0] iso_err_o
);

    typedef enum logic [1:0] {
        ST_ON          = 2'b00,
        ST_TURNING_OFF = 2'b01,
        ST_OFF         = 2'b11,
        ST_TURNING_ON  = 2'b10
    } state_t;

    localparam logic [7:0] LOAD = 8'(LATENCY - 1);

    state_t                 r_state [NUM_DOMAINS];
    logic [7:0]             r_cnt   [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] r_ack;
    logic [NUM_DOMAINS-1:0] r_iso_err;
    logic                   r_busy;
    logic                   r_abort;
    logic [7:0]             r_abort_cnt;

    logic [NUM_DOMAINS-1:0] w_turning;
    logic [NUM_DOMAINS-1:0] w_abort;
    logic [NUM_DOMAINS-1:0] w_start;
    logic [NUM_DOMAINS-1:0] w_done;
    logic                   w_busy_nxt;
    logic [15:0]            w_abort_num;
    logic [15:0]            w_cnt_sum;

    // A transition is cancelled when the request returns to the side the domain came from.
    always_comb begin
        w_turning   = '0;
        w_abort     = '0;
        w_start     = '0;
        w_done      = '0;
        w_abort_num = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            w_turning[d] = (r_state[d] == ST_TURNING_OFF) || (r_state[d] == ST_TURNING_ON);
            w_abort[d]   = ((r_state[d] == ST_TURNING_OFF) && !switch_n_i[d]) ||
                           ((r_state[d] == ST_TURNING_ON)  &&  switch_n_i[d]);
            w_start[d]   = ((r_state[d] == ST_ON)  &&  switch_n_i[d]) ||
                           ((r_state[d] == ST_OFF) && !switch_n_i[d]);
            w_done[d]    = w_turning[d] && !w_abort[d] && (r_cnt[d] == 8'd0);
            w_abort_num  = w_abort_num + 16'(w_abort[d]);
        end
        w_busy_nxt = |(w_start | (w_turning & ~w_abort & ~w_done));
        w_cnt_sum  = 16'(r_abort_cnt) + w_abort_num;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                r_state[d] <= ST_ON;
                r_cnt[d]   <= 8'd0;
            end
            r_ack       <= '0;
            r_iso_err   <= '0;
            r_busy      <= 1'b0;
            r_abort     <= 1'b0;
            r_abort_cnt <= 8'd0;
        end else begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                case (r_state[d])
                    ST_ON: begin
                        if (switch_n_i[d]) begin
                            r_state[d] <= ST_TURNING_OFF;
                            r_cnt[d]   <= LOAD;
                        end
                    end
                    ST_TURNING_OFF: begin
                        if (w_abort[d]) begin
                            r_state[d] <= ST_ON;
                            r_cnt[d]   <= 8'd0;
                        end else if (r_cnt[d] == 8'd0) begin
                            r_state[d] <= ST_OFF;
                            r_ack[d]   <= 1'b1;
                        end else begin
                            r_cnt[d] <= r_cnt[d] - 8'd1;
                        end
                    end
                    ST_OFF: begin
                        if (!switch_n_i[d]) begin
                            r_state[d] <= ST_TURNING_ON;
                            r_cnt[d]   <= LOAD;
                        end
                    end
                    ST_TURNING_ON: begin
                        if (w_abort[d]) begin
                            r_state[d] <= ST_OFF;
                            r_cnt[d]   <= 8'd0;
                        end else if (r_cnt[d] == 8'd0) begin
                            r_state[d] <= ST_ON;
                            r_ack[d]   <= 1'b0;
                        end else begin
                            r_cnt[d] <= r_cnt[d] - 8'd1;
                        end
                    end
                    default: begin
                        r_state[d] <= ST_ON;
                        r_cnt[d]   <= 8'd0;
                    end
                endcase
            end

            r_busy  <= w_busy_nxt;
            r_abort <= |w_abort;

            // A coincident abort beats the clear.
            if (|w_abort) begin
                r_abort_cnt <= (w_cnt_sum > 16'd255) ? 8'hFF : w_cnt_sum[7:0];
            end else if (clr_i) begin
                r_abort_cnt <= 8'd0;
            end

            r_iso_err <= (clr_i ? '0 : r_iso_err) | (r_ack & iso_n_i);
        end
    end

    assign switch_ack_no = r_ack;
    assign busy_o        = r_busy;
    assign abort_o       = r_abort;
    assign abort_cnt_o   = r_abort_cnt;
    assign iso_err_o     = r_iso_err;

endmodule

// File: tb/tb_power_switch_emulator.sv
// Randomized + directed bench for power_switch_emulator (LATENCY=15 and LATENCY=1 instances side by side).
module tb_power_switch_emulator;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw, iso;
    logic         clr;

    logic [N-1:0] ack15, ack1, err15, err1;
    logic         busy15, busy1, ab15, ab1;
    logic [7:0]   cnt15, cnt1;

    always #5 clk = ~clk;

    power_switch_emulator #(.NUM_DOMAINS(N), .LATENCY(15)) u_l15 (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw), .iso_n_i(iso), .clr_i(clr),
        .switch_ack_no(ack15), .busy_o(busy15), .abort_o(ab15),
        .abort_cnt_o(cnt15), .iso_err_o(err15));

    power_switch_emulator #(.NUM_DOMAINS(N), .LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw), .iso_n_i(iso), .clr_i(clr),
        .switch_ack_no(ack1), .busy_o(busy1), .abort_o(ab1),
        .abort_cnt_o(cnt1), .iso_err_o(err1));

    typedef struct packed {
        logic [N-1:0] ack;
        logic         busy;
        logic         abort;
        logic [7:0]   cnt;
        logic [N-1:0] err;
    } obs_t;

    typedef struct packed {
        obs_t a;  // LATENCY=15 instance
        obs_t b;  // LATENCY=1 instance
    } pair_t;

    pair_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;

    // Reference model: a pending request remembers the edge it was first seen on.
    int           lat [2] = '{15, 1};
    logic [N-1:0] m_ack  [2];
    logic [N-1:0] m_pend [2];
    int           m_start[2][N];
    int           m_cnt  [2];
    logic [N-1:0] m_err  [2];
    int           edge_no = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ack[i]  = '0;
            m_pend[i] = '0;
            m_cnt[i]  = 0;
            m_err[i]  = '0;
            for (int d = 0; d < N; d++) m_start[i][d] = 0;
        end
    endtask

    task automatic model_step(output pair_t e);
        obs_t o[2];
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            int           n = 0;
            logic [N-1:0] ack_before = m_ack[i];
            for (int d = 0; d < N; d++) begin
                if (sw[d] == m_ack[i][d]) begin
                    if (m_pend[i][d]) begin
                        n++;
                        m_pend[i][d] = 1'b0;
                    end
                end else if (!m_pend[i][d]) begin
                    m_pend[i][d]  = 1'b1;
                    m_start[i][d] = edge_no;
                end else if (edge_no - m_start[i][d] == lat[i]) begin
                    m_ack[i][d]  = sw[d];
                    m_pend[i][d] = 1'b0;
                end
            end
            if (n > 0) m_cnt[i] = (m_cnt[i] + n > 255) ? 255 : m_cnt[i] + n;
            else if (clr) m_cnt[i] = 0;
            m_err[i] = (clr ? '0 : m_err[i]) | (ack_before & iso);
            o[i].ack   = m_ack[i];
            o[i].busy  = |m_pend[i];
            o[i].abort = (n > 0);
            o[i].cnt   = 8'(m_cnt[i]);
            o[i].err   = m_err[i];
        end
        e.a = o[0];
        e.b = o[1];
    endtask

    task automatic cycle(input logic r, input logic [N-1:0] s, input logic [N-1:0] is, input logic c);
        pair_t e;
        @(negedge clk);
        rst_n = r;
        sw    = s;
        iso   = is;
        clr   = c;
        if (!r) begin
            model_reset();
            e = '0;
            exp_q.push_back(e);
            #1;
            chk("async_rst_ack15", 32'(ack15), 32'd0);
            chk("async_rst_ack1",  32'(ack1),  32'd0);
            chk("async_rst_busy",  32'({busy15, busy1, ab15, ab1}), 32'd0);
            chk("async_rst_cnt",   32'({cnt15, cnt1}), 32'd0);
            chk("async_rst_err",   32'({err15, err1}), 32'd0);
        end else begin
            model_step(e);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compares every post-edge output against the queued expectation.
    initial begin
        pair_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ack15",   32'(ack15),  32'(e.a.ack));
                chk("busy15",  32'(busy15), 32'(e.a.busy));
                chk("abort15", 32'(ab15),   32'(e.a.abort));
                chk("cnt15",   32'(cnt15),  32'(e.a.cnt));
                chk("err15",   32'(err15),  32'(e.a.err));
                chk("ack1",    32'(ack1),   32'(e.b.ack));
                chk("busy1",   32'(busy1),  32'(e.b.busy));
                chk("abort1",  32'(ab1),    32'(e.b.abort));
                chk("cnt1",    32'(cnt1),   32'(e.b.cnt));
                chk("err1",    32'(err1),   32'(e.b.err));
            end
        end
    end

    initial begin
        logic [N-1:0] s;
        logic [N-1:0] is;
        rst_n = 1'b0;
        sw    = '0;
        iso   = '0;
        clr   = 1'b0;
        model_reset();

        repeat (3) cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Single domain off then on again.
        repeat (20) cycle(1'b1, 4'b0001, 4'b0000, 1'b0);
        repeat (20) cycle(1'b1, 4'b0000, 4'b0000, 1'b0);

        // Short request on domain 1 that gets cancelled.
        repeat (5) cycle(1'b1, 4'b0010, 4'b0000, 1'b0);
        repeat (5) cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
        chk("abort_cnt_after_cancel", 32'(cnt15), 32'd1);

        // All domains off together, then an isolation violation on domain 2.
        repeat (18) cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
        repeat (2)  cycle(1'b1, 4'b1111, 4'b0100, 1'b0);
        cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
        chk("iso_err_sticky", 32'(err15), 32'h4);
        repeat (3)  cycle(1'b1, 4'b1111, 4'b0000, 1'b0);
        cycle(1'b1, 4'b1111, 4'b0000, 1'b1);
        repeat (18) cycle(1'b1, 4'b0000, 4'b0000, 1'b0);

        // Reset in the middle of a turn-off with the request held.
        repeat (8)  cycle(1'b1, 4'b0001, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
        repeat (20) cycle(1'b1, 4'b0001, 4'b0000, 1'b0);

        // Random traffic.
        s = 4'b0001;
        for (int i = 0; i < 2000; i++) begin
            for (int d = 0; d < N; d++) if ($urandom_range(9) == 0) s[d] = ~s[d];
            is = N'($urandom);
            cycle(($urandom_range(499) != 0), s, is, ($urandom_range(24) == 0));
        end

        // Back-to-back cancellations drive the counter into saturation.
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 600; i++) cycle(1'b1, {3'b000, 1'(i % 2 == 0)}, 4'b0000, 1'b0);
        repeat (2) cycle(1'b1, 4'b0000, 4'b0000, 1'b0);
        chk("sat_cnt15", 32'(cnt15), 32'd255);
        chk("sat_cnt1",  32'(cnt1),  32'd255);
        repeat (2) cycle(1'b1, 4'b0000, 4'b0000, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/power_switch_emulator.md
POWER_SWITCH_EMULATOR -- requirements
Module: power_switch_emulator

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4: number of independent power domains emulated.
REQ-002 SHALL have parameter LATENCY, default 15: cycles from a sampled switch request to the ack change; legal range 1..255.
REQ-003 SHALL have port clk_i  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port switch_n_i  input  NUM_DOMAINS: per-domain power switch request (0 = power on, 1 = power off).
REQ-006 SHALL have port iso_n_i  input  NUM_DOMAINS: per-domain isolation enable (0 = isolated).
REQ-007 SHALL have port clr_i  input  1: synchronous clear of sticky status and counters.
REQ-008 SHALL have port switch_ack_no  output  NUM_DOMAINS: per-domain switch acknowledge (0 = powered, 1 = off).
REQ-009 SHALL have port busy_o  output  1: high while any domain is mid-transition.
REQ-010 SHALL have port abort_o  output  1: one-cycle pulse when any transition is cancelled.
REQ-011 SHALL have port abort_cnt_o  output  8: saturating count of cancelled transitions.
REQ-012 SHALL have port iso_err_o  output  NUM_DOMAINS: sticky per-domain isolation violation flag.

Function
REQ-013 SHALL implement per-domain FSM with states ON, TURNING_OFF, OFF, TURNING_ON, plus an 8-bit down counter.
REQ-014 ON: switch_n_i[d]=1 sampled -> TURNING_OFF, counter loaded LATENCY-1; switch_ack_no[d] stays 0.
REQ-015 OFF: switch_n_i[d]=0 sampled -> TURNING_ON, counter loaded LATENCY-1; switch_ack_no[d] stays 1.
REQ-016 In TURNING_*: counter decrements each edge while request unchanged; edge with counter==0 -> OFF/ON respectively and ack flips.
REQ-017 Latency: request first sampled at edge k SHALL flip switch_ack_no[d] at edge k+LATENCY exactly (LATENCY=1 -> next edge).
REQ-018 Abort: in TURNING_OFF with switch_n_i[d]=0 (or TURNING_ON with 1) -> return to ON (resp. OFF) on that edge, ack unchanged, counter cleared.
REQ-019 abort_o SHALL be high the cycle after any abort edge; multiple simultaneous domain aborts -> single pulse, abort_cnt_o += number aborting, saturating at 255.
REQ-020 A request re-asserted after abort SHALL restart the full LATENCY count.
REQ-021 busy_o SHALL equal OR over domains of (state in TURNING_OFF/TURNING_ON), registered with state (no combinational path from switch_n_i).
REQ-022 iso_err_o[d] SHALL set on any edge where switch_ack_no[d]=1 and iso_n_i[d]=1; remains set until clr_i or reset.
REQ-023 clr_i SHALL clear iso_err_o and abort_cnt_o on that edge; if a violation/abort coincides with clr_i, set/increment wins.
REQ-024 Domains SHALL be fully independent; simultaneous transitions in all domains SHALL each meet REQ-017.
REQ-025 switch_ack_no SHALL be driven directly from state flops (glitch-free).

Reset
REQ-026 rst_ni low SHALL asynchronously force all domains to ON, counters 0, switch_ack_no all 0, busy_o 0, abort_o 0, abort_cnt_o 0, iso_err_o 0.
REQ-027 Reset asserted mid-transition SHALL discard the transition; after release a held switch_n_i=1 starts a fresh LATENCY count from the first sampling edge.

Verification
REQ-028 LATENCY=15, domain 0 switch_n_i 0->1 before edge k -> switch_ack_no[0]=1 after edge k+15, busy_o high edges k..k+14 window, low after.
REQ-029 LATENCY=15, switch_n_i[1]=1 for 5 cycles then 0 -> switch_ack_no[1] never rises, abort_o one pulse, abort_cnt_o=1.
REQ-030 All 4 domains request off on same edge -> all acks rise on same edge k+15; then domain 2 off with iso_n_i[2]=1 -> iso_err_o=4'b0100 sticky until clr_i.
REQ-031 rst_ni pulsed low at count 7 of TURNING_OFF with request held -> acks 0 immediately, ack rises 15 edges after first post-reset edge.
REQ-032 LATENCY=1 -> ack follows request by exactly one edge; 300 abort cycles -> abort_cnt_o saturates at 255.
